// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared OPMODE layout, operand select encodings and width defaults
package dsp_pkg;

  localparam int MW_DEFAULT = 36;
  localparam int PW_DEFAULT = 48;

  localparam int OPM_W     = 5;
  localparam int OPM_X_LSB = 0;
  localparam int OPM_Z_LSB = 2;
  localparam int OPM_SUB   = 4;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } xsel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } zsel_e;

  function automatic logic [OPM_W-1:0] make_opmode(xsel_e x, zsel_e z, logic sub);
    return {sub, z, x};
  endfunction

endpackage

// File: rtl/dsp_post_accumulator_if.sv
// rtl/dsp_post_accumulator_if.sv - operand/result bundle between the multiplier pipe and the P stage
interface dsp_post_accumulator_if
  import dsp_pkg::*;
#(
  parameter int MW = MW_DEFAULT,
  parameter int PW = PW_DEFAULT
);

  logic             ce_p;
  logic             clr_ovf;
  logic             in_valid;
  logic [OPM_W-1:0] opmode;
  logic             carry_in;
  logic [MW-1:0]    m;
  logic [PW-1:0]    dab;
  logic [PW-1:0]    c;
  logic [PW-1:0]    pcin;
  logic [PW-1:0]    p;
  logic [PW-1:0]    pcout;
  logic             carry_out;
  logic             ovf;
  logic             op_err;
  logic             p_valid;

  modport master (
    output ce_p, clr_ovf, in_valid, opmode, carry_in, m, dab, c, pcin,
    input  p, pcout, carry_out, ovf, op_err, p_valid
  );

  modport slave (
    input  ce_p, clr_ovf, in_valid, opmode, carry_in, m, dab, c, pcin,
    output p, pcout, carry_out, ovf, op_err, p_valid
  );

endinterface

// File: rtl/dsp_post_adder.sv
// rtl/dsp_post_adder.sv - combinational add/subtract with carry-in, carry-out and signed overflow
module dsp_post_adder #(
  parameter int PW = 48
) (
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] z,
  input  logic          carry_in,
  input  logic          sub,
  output logic [PW-1:0] sum,
  output logic          carry_out,
  output logic          ovf_flag
);

  logic [PW:0]   ext;
  logic [PW:0]   cin_ext;
  logic [PW-1:0] x_eff;

  assign cin_ext = {{PW{1'b0}}, carry_in};

  always_comb begin
    ext = '0;
    if (sub) begin
      ext = {1'b0, z} - {1'b0, x} - cin_ext;
    end else begin
      ext = {1'b0, z} + {1'b0, x} + cin_ext;
    end
  end

  assign sum       = ext[PW-1:0];
  assign carry_out = ext[PW];

  // For add the carry is folded into X before the sign comparison.
  assign x_eff = x + cin_ext[PW-1:0];

  always_comb begin
    ovf_flag = 1'b0;
    if (sub) begin
      ovf_flag = (z[PW-1] != x[PW-1]) && (sum[PW-1] != z[PW-1]);
    end else begin
      ovf_flag = (z[PW-1] == x_eff[PW-1]) && (sum[PW-1] != z[PW-1]);
    end
  end

endmodule

// File: rtl/dsp_post_accumulator.sv
// rtl/dsp_post_accumulator.sv - operand muxes, post-adder and P register with sticky overflow
module dsp_post_accumulator
  import dsp_pkg::*;
#(
  parameter int PREG = 1,
  parameter int MW   = MW_DEFAULT,
  parameter int PW   = PW_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  dsp_post_accumulator_if.slave bus
);

  xsel_e         x_sel;
  zsel_e         z_sel;
  logic          sub;
  logic [PW-1:0] p_fb;
  logic [PW-1:0] x_op;
  logic [PW-1:0] z_op;
  logic [PW-1:0] sum;
  logic          carry_nx;
  logic          ovf_flag;
  logic [PW-1:0] p_out;

  assign x_sel = xsel_e'(bus.opmode[OPM_X_LSB +: 2]);
  assign z_sel = zsel_e'(bus.opmode[OPM_Z_LSB +: 2]);
  assign sub   = bus.opmode[OPM_SUB];

  always_comb begin
    x_op = '0;
    case (x_sel)
      X_ZERO:  x_op = '0;
      X_M:     x_op = {{(PW-MW){1'b0}}, bus.m};
      X_P:     x_op = p_fb;
      X_DAB:   x_op = bus.dab;
      default: x_op = '0;
    endcase
  end

  always_comb begin
    z_op = '0;
    case (z_sel)
      Z_ZERO:  z_op = '0;
      Z_PCIN:  z_op = bus.pcin;
      Z_P:     z_op = p_fb;
      Z_C:     z_op = bus.c;
      default: z_op = '0;
    endcase
  end

  dsp_post_adder #(.PW(PW)) u_adder (
    .x         (x_op),
    .z         (z_op),
    .carry_in  (bus.carry_in),
    .sub       (sub),
    .sum       (sum),
    .carry_out (carry_nx),
    .ovf_flag  (ovf_flag)
  );

  generate
    if (PREG != 0) begin : g_preg
      logic [PW-1:0] p_q;
      logic          carry_q;
      logic          ovf_q;
      logic          valid_q;

      // clr_ovf wins over an overflow raised in the same cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_q     <= '0;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b0;
        end else if (bus.ce_p) begin
          p_q     <= sum;
          carry_q <= carry_nx;
          valid_q <= bus.in_valid;
          if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
          end else if (bus.in_valid) begin
            ovf_q <= ovf_q | ovf_flag;
          end
        end
      end

      assign p_fb          = p_q;
      assign p_out         = p_q;
      assign bus.carry_out = carry_q;
      assign bus.ovf       = ovf_q;
      assign bus.p_valid   = valid_q;
      assign bus.op_err    = 1'b0;
    end else begin : g_comb
      // No P register exists, so feedback reads as zero and is flagged.
      assign p_fb          = '0;
      assign p_out         = sum;
      assign bus.carry_out = carry_nx;
      assign bus.ovf       = bus.in_valid & ovf_flag;
      assign bus.p_valid   = bus.in_valid;
      assign bus.op_err    = (x_sel == X_P) || (z_sel == Z_P);
    end
  endgenerate

  assign bus.p     = p_out;
  assign bus.pcout = p_out;

endmodule

// File: tb/tb_dsp_post_accumulator.sv
// tb/tb_dsp_post_accumulator.sv - directed checks of the P stage with and without the P register
module tb_dsp_post_accumulator;
  import dsp_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dsp_post_accumulator_if ia ();
  dsp_post_accumulator_if ib ();

  dsp_post_accumulator #(.PREG(1)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  dsp_post_accumulator #(.PREG(0)) u_comb (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ia.ce_p = 1'b1; ia.clr_ovf = 1'b0; ia.in_valid = 1'b0;
    ia.opmode = make_opmode(X_ZERO, Z_ZERO, 1'b0); ia.carry_in = 1'b0;
    ia.m = '0; ia.dab = '0; ia.c = '0; ia.pcin = '0;
    ib.ce_p = 1'b1; ib.clr_ovf = 1'b0; ib.in_valid = 1'b0;
    ib.opmode = make_opmode(X_ZERO, Z_ZERO, 1'b0); ib.carry_in = 1'b0;
    ib.m = '0; ib.dab = '0; ib.c = '0; ib.pcin = '0;
    tick();
    tick();

    check("rst_p",       ia.p, 48'd0);
    check("rst_pcout",   ia.pcout, 48'd0);
    check("rst_carry",   {47'd0, ia.carry_out}, 48'd0);
    check("rst_ovf",     {47'd0, ia.ovf}, 48'd0);
    check("rst_p_valid", {47'd0, ia.p_valid}, 48'd0);
    check("rst_op_err",  {47'd0, ia.op_err}, 48'd0);
    rst = 1'b0;

    // multiply-accumulate 3 per cycle
    ia.opmode = make_opmode(X_M, Z_P, 1'b0);
    ia.m = 36'd3;
    ia.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("mac_p_%0d", i), ia.p, 48'(3 * i));
      check($sformatf("mac_valid_%0d", i), {47'd0, ia.p_valid}, 48'd1);
    end
    check("mac_pcout", ia.pcout, 48'd12);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_p",     ia.p, 48'd0);
    check("async_rst_valid", {47'd0, ia.p_valid}, 48'd0);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_acc", ia.p, 48'd3);

    // subtract with borrow: 10 - 3 - 1
    ia.opmode = make_opmode(X_DAB, Z_C, 1'b1);
    ia.c = 48'd10; ia.dab = 48'd3; ia.carry_in = 1'b1;
    tick();
    check("sub_p",     ia.p, 48'd6);
    check("sub_carry", {47'd0, ia.carry_out}, 48'd0);

    // underflow 0 - 1
    ia.c = 48'd0; ia.dab = 48'd1; ia.carry_in = 1'b0;
    tick();
    check("uflow_p",     ia.p, 48'hFFFF_FFFF_FFFF);
    check("uflow_carry", {47'd0, ia.carry_out}, 48'd1);
    check("uflow_ovf",   {47'd0, ia.ovf}, 48'd0);

    // signed overflow: max positive + 1
    ia.opmode = make_opmode(X_DAB, Z_C, 1'b0);
    ia.c = 48'h7FFF_FFFF_FFFF; ia.dab = 48'd1;
    tick();
    check("sovf_p",     ia.p, 48'h8000_0000_0000);
    check("sovf_ovf",   {47'd0, ia.ovf}, 48'd1);
    check("sovf_carry", {47'd0, ia.carry_out}, 48'd0);

    ia.opmode = make_opmode(X_ZERO, Z_P, 1'b0);
    ia.in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("sticky_ovf_%0d", i), {47'd0, ia.ovf}, 48'd1);
      check($sformatf("hold_p_%0d", i), ia.p, 48'h8000_0000_0000);
      check($sformatf("bubble_valid_%0d", i), {47'd0, ia.p_valid}, 48'd0);
    end
    ia.clr_ovf = 1'b1;
    tick();
    ia.clr_ovf = 1'b0;
    check("clr_ovf", {47'd0, ia.ovf}, 48'd0);

    // clear has priority over a same-cycle overflow
    ia.opmode = make_opmode(X_DAB, Z_C, 1'b0);
    ia.c = 48'h7FFF_FFFF_FFFF; ia.dab = 48'd1; ia.in_valid = 1'b1;
    ia.clr_ovf = 1'b1;
    tick();
    ia.clr_ovf = 1'b0;
    check("clr_prio_ovf", {47'd0, ia.ovf}, 48'd0);
    check("clr_prio_p",   ia.p, 48'h8000_0000_0000);

    // unsigned wrap is not a signed overflow
    ia.c = 48'hFFFF_FFFF_FFFF; ia.dab = 48'd1;
    tick();
    check("wrap_p",     ia.p, 48'd0);
    check("wrap_carry", {47'd0, ia.carry_out}, 48'd1);
    check("wrap_ovf",   {47'd0, ia.ovf}, 48'd0);

    // clock enable freezes the accumulator mid-run
    ia.opmode = make_opmode(X_M, Z_P, 1'b0);
    ia.m = 36'd3;
    tick();
    tick();
    check("ce_pre_p", ia.p, 48'd6);
    ia.ce_p = 1'b0;
    ia.in_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check($sformatf("ce_hold_p_%0d", i), ia.p, 48'd6);
      check($sformatf("ce_hold_valid_%0d", i), {47'd0, ia.p_valid}, 48'd1);
      check($sformatf("ce_hold_ovf_%0d", i), {47'd0, ia.ovf}, 48'd0);
    end
    ia.ce_p = 1'b1;
    ia.in_valid = 1'b1;
    tick();
    check("ce_resume_p", ia.p, 48'd9);

    // PREG=0: same-cycle result
    ib.opmode = make_opmode(X_M, Z_C, 1'b0);
    ib.m = 36'd5; ib.c = 48'd7; ib.in_valid = 1'b1;
    #1;
    check("comb_p",      ib.p, 48'd12);
    check("comb_pcout",  ib.pcout, 48'd12);
    check("comb_op_err", {47'd0, ib.op_err}, 48'd0);
    check("comb_valid",  {47'd0, ib.p_valid}, 48'd1);

    ib.opmode = make_opmode(X_M, Z_P, 1'b0);
    ib.carry_in = 1'b1;
    #1;
    check("comb_fb_p",      ib.p, 48'd6);
    check("comb_fb_op_err", {47'd0, ib.op_err}, 48'd1);

    ib.in_valid = 1'b0;
    #1;
    check("comb_bubble_valid", {47'd0, ib.p_valid}, 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_post_accumulator.md
# dsp_post_accumulator

Post-adder/accumulator stage of the DSP slice. It sits directly downstream of the input and multiplier pipeline registers and consumes the 36-bit product M, the concatenated D:A:B operand, C and the cascade input PCIN. It selects operands via OPMODE, adds or subtracts them with carry-in, and holds the result in the P register. P can be fed back to form a multiply-accumulate loop, with sticky signed-overflow detection.

## Interface
Parameters:
- PREG, 1, 1 = P, CARRYOUT, OVF and P_VALID registered; 0 = combinational pass-through
- MW, 36, product width
- PW, 48, result/accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; clears every register in the block
- ce_p  in  1  clock enable for all P-stage registers
- clr_ovf  in  1  synchronous clear of sticky overflow (honoured only when ce_p=1)
- in_valid  in  1  operands valid this cycle
- opmode  in  5  [1:0] X sel, [3:2] Z sel, [4] subtract
- carry_in  in  1  carry/borrow in
- m  in  MW  product, zero-extended to PW
- dab  in  PW  D[11:0]:A:B concatenation
- c  in  PW  C operand
- pcin  in  PW  cascade input from the neighbouring slice
- p  out  PW  result
- pcout  out  PW  copy of p for cascade
- carry_out  out  1  bit PW of the extended sum
- ovf  out  1  sticky signed overflow
- op_err  out  1  P feedback selected while PREG=0
- p_valid  out  1  result valid

## Operation
- X mux values: 0 → 0; 1 → {12'b0, m}; 2 → p; 3 → dab.
- Z mux values: 0 → 0; 1 → pcin; 2 → p; 3 → c.
- Add (opmode[4]=0): ext = {1'b0,Z} + {1'b0,X} + carry_in, 49 bits.
- Subtract (opmode[4]=1): ext = {1'b0,Z} − {1'b0,X} − carry_in, 49-bit two's complement.
- Result assignment: p_next = ext[47:0]; carry_out_next = ext[48].
- Signed overflow flag:
  - add: Z[47]==X'[47] && p_next[47]!=Z[47], where X' = X (+carry folded in).
  - sub: Z[47]!=X[47] && p_next[47]!=Z[47].
- Sticky overflow: ovf_next = ovf | ovf_flag when in_valid. clr_ovf has priority over a same-cycle new overflow: the result is 0, and the flag of that cycle is discarded.
- Accumulate with in_valid=0: p still updates when ce_p=1, so bubbles must drive opmode X=0/Z=2 (hold) or be gated upstream. p_valid tracks in_valid.
- PREG=0: outputs are combinational from the inputs. Selecting X=2 or Z=2 substitutes 0 for p and asserts op_err for that cycle. With PREG=1, op_err is always 0.
- ce_p=0: all P-stage registers, including p_valid and ovf, hold.

## Timing
- Latency PREG=1: 1 cycle, inputs at edge n → p/carry_out/ovf/p_valid at edge n+1.
- Latency PREG=0: 0 cycles.
- Feedback: an accumulate in cycle n uses the p registered at edge n. Back-to-back MACs need no stall.
- Reset values: p=0, pcout=0, carry_out=0, ovf=0, p_valid=0, op_err=0.
- Reset is asynchronous, so it takes effect mid-accumulation immediately, regardless of ce_p. The first valid operand after deassertion accumulates from 0.
- Wrap-around: unsigned overflow wraps modulo 2^48, with carry_out=1. This is not an error and does not set ovf.

## Structure
- Shared package dsp_pkg holds:
  - OPMODE field positions;
  - X/Z select encodings (X_ZERO, X_M, X_P, X_DAB; Z_ZERO, Z_PCIN, Z_P, Z_C);
  - MW/PW defaults.
- One sub-module: dsp_post_adder, combinational. It takes the X, Z, carry_in and sub inputs and produces the 48-bit sum, carry_out and ovf_flag.
- The top level holds the operand muxes, P-stage registers, sticky logic and the PREG generate.

## Test plan
- Reset mid-accumulation:
  - PREG=1, opmode=X_M|Z_P, m=3, in_valid=1 for 4 cycles → p=3,6,9,12.
  - Then assert rst asynchronously → p=0 and p_valid=0 before the next edge.
- Subtract with borrow: opmode=X_DAB|Z_C|sub, c=10, dab=3, carry_in=1 → p=6, carry_out=0.
- Underflow: c=0, dab=1 → p=0xFFFF_FFFF_FFFF, carry_out=1, ovf=0.
- Signed overflow:
  - add Z=c=0x7FFF_FFFF_FFFF, X=dab=1 → p=0x8000_0000_0000 and ovf=1.
  - ovf stays 1 over the next 3 cycles; a clr_ovf pulse returns it to 0.
- Clock enable: ce_p=0 for 2 cycles during an accumulate → p, p_valid and ovf are unchanged, and accumulation resumes correctly when ce_p=1.
- PREG=0:
  - opmode=X_M|Z_C, m=5, c=7 → p=12 in the same cycle.
  - Selecting Z_P → op_err=1 and p=X+carry_in.
